logic_op_identifier: RTL and testbench

LOGIC_OP_IDENTIFIER -- requirements
Module: logic_op_identifier

---
 rtl/logic_op_identifier_pkg.sv | 18 +
 rtl/logic_op_identifier_tt_to_sel.sv | 20 ++
 rtl/logic_op_identifier.sv | 77 +++++++
 tb/tb_logic_op_identifier.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/logic_op_identifier_pkg.sv
// logic_op_identifier_pkg: shared states, truth-pattern constants and select codes
package logic_op_identifier_pkg;
  typedef enum logic [1:0] {IDLE, PROBE, DECODE, DONE} state_t;
  localparam logic [3:0] TT_NOT  = 4'b0011;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [2:0] SEL_NOT  = 3'd0;
  localparam logic [2:0] SEL_NOR  = 3'd1;
  localparam logic [2:0] SEL_AND  = 3'd2;
  localparam logic [2:0] SEL_OR   = 3'd3;
  localparam logic [2:0] SEL_XOR  = 3'd4;
  localparam logic [2:0] SEL_XNOR = 3'd5;
  localparam logic [2:0] SEL_NAND = 3'd6;
endpackage

// File: rtl/logic_op_identifier_tt_to_sel.sv
// tt_to_sel: combinational map from a captured truth table to its select code
module tt_to_sel
  import logic_op_identifier_pkg::*;
(
  input  logic [3:0] truth,
  output logic [2:0] sel,
  output logic       match
);
  // unknown patterns fall through to code 0 with match low
  always_comb begin
    sel = truth == TT_NOT  ? SEL_NOT  :
          truth == TT_NOR  ? SEL_NOR  :
          truth == TT_AND  ? SEL_AND  :
          truth == TT_OR   ? SEL_OR   :
          truth == TT_XOR  ? SEL_XOR  :
          truth == TT_XNOR ? SEL_XNOR :
          truth == TT_NAND ? SEL_NAND : 3'd0;
    match = truth inside {TT_NOT, TT_NOR, TT_AND, TT_OR, TT_XOR, TT_XNOR, TT_NAND};
  end
endmodule

// File: rtl/logic_op_identifier.sv
// logic_op_identifier: probes a two-input logic unit at all four points and names its operation
module logic_op_identifier
  import logic_op_identifier_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       unit_out,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] sel_found,
  output logic       valid,
  output logic       err
);
  localparam logic [2:0] HOLD_LAST = 3'(SETTLE);
  state_t     state;
  logic [1:0] idx;
  logic [2:0] hold;
  logic [2:0] dec_sel;
  logic       dec_match;
  tt_to_sel u_dec (.truth(truth), .sel(dec_sel), .match(dec_match));
  // run sequencer: walk the four probe points, decode, then publish for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      hold      <= 3'd0;
      probe_a   <= 1'b0;
      probe_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= 4'd0;
      sel_found <= 3'd0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state              <= PROBE;
            busy               <= 1'b1;
            idx                <= 2'd0;
            hold               <= 3'd0;
            truth              <= 4'd0;
            valid              <= 1'b0;
            err                <= 1'b0;
            {probe_a, probe_b} <= 2'b00;
          end else state <= IDLE;
        end
        PROBE: begin
          if (hold == HOLD_LAST) begin
            truth[idx]         <= unit_out;
            hold               <= 3'd0;
            idx                <= idx + 2'd1;
            {probe_a, probe_b} <= idx + 2'd1;
            if (idx == 2'd3) state <= DECODE;
          end else hold <= hold + 3'd1;
        end
        DECODE: begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          sel_found <= dec_sel;
          valid     <= dec_match;
          err       <= !dec_match;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_op_identifier.sv
// tb_logic_op_identifier: scoreboard bench driving two identifiers (SETTLE 0 and 2) against a model unit
module tb_logic_op_identifier;
  typedef struct {
    logic [3:0] tr;
    logic [2:0] sf;
    logic       v;
    logic       e;
    int         dc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s0 = 1'b0, s2 = 1'b0;
  logic [2:0] sel0 = 3'd0, sel2 = 3'd0;
  logic [1:0] tie2 = 2'b00;
  logic u0_out, u2_out;
  logic a0, b0, busy0, done0, v0, e0;
  logic a2, b2, busy2, done2, v2, e2;
  logic [3:0] tr0, tr2;
  logic [2:0] sf0, sf2;
  exp_t q0[$], q2[$];
  exp_t x0, x2;
  int cyc = 0;
  int nvec = 0, nerr = 0;
  logic [3:0] ett [8] = '{4'b0011, 4'b0001, 4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b0111, 4'b0111};
  int esf [8] = '{0, 1, 2, 3, 4, 5, 6, 6};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic op(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0: op = !a;
      3'd1: op = !(a | b);
      3'd2: op = a & b;
      3'd3: op = a | b;
      3'd4: op = a ^ b;
      3'd5: op = !(a ^ b);
      default: op = !(a & b);
    endcase
  endfunction

  assign u0_out = op(sel0, a0, b0);
  assign u2_out = tie2[1] ? tie2[0] : op(sel2, a2, b2);

  logic_op_identifier #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(s0), .unit_out(u0_out), .probe_a(a0), .probe_b(b0),
    .busy(busy0), .done(done0), .truth(tr0), .sel_found(sf0), .valid(v0), .err(e0));
  logic_op_identifier #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .unit_out(u2_out), .probe_a(a2), .probe_b(b2),
    .busy(busy2), .done(done2), .truth(tr2), .sel_found(sf2), .valid(v2), .err(e2));

  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string u, input exp_t x, input logic [3:0] tr, input logic [2:0] sf,
                     input logic v, input logic e);
    chk({u, " truth"}, int'(tr), int'(x.tr));
    chk({u, " sel_found"}, int'(sf), int'(x.sf));
    chk({u, " valid"}, int'(v), int'(x.v));
    chk({u, " err"}, int'(e), int'(x.e));
    chk({u, " done_cycle"}, cyc, x.dc);
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("u0 unexpected_done", 1, 0);
      else begin
        x0 = q0.pop_front();
        cmp("u0", x0, tr0, sf0, v0, e0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("u2 unexpected_done", 1, 0);
      else begin
        x2 = q2.pop_front();
        cmp("u2", x2, tr2, sf2, v2, e2);
      end
    end
  end

  task automatic go2(input logic [2:0] s, input logic [1:0] tie, input bit push,
                     input logic [3:0] tr, input logic [2:0] sf, input logic v, input logic e,
                     output int t);
    @(negedge clk);
    sel2 = s;
    tie2 = tie;
    s2 = 1'b1;
    t = cyc + 1;
    if (push) q2.push_back('{tr, sf, v, e, t + 13});
  endtask

  task automatic wait_idle(input bit w);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((w ? (busy2 | done2) : (busy0 | done0)) && n < 300);
    if (n >= 300) chk(w ? "u2 idle_timeout" : "u0 idle_timeout", 1, 0);
  endtask

  initial begin
    int t, n;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy2), 0);
    chk("rst done", int'(done2), 0);
    chk("rst truth", int'(tr2), 0);
    chk("rst sel_found", int'(sf2), 0);
    chk("rst valid_err", int'({v2, e2}), 0);
    chk("rst probes", int'({a2, b2}), 0);
    @(negedge clk);
    rst = 1'b0;
    sel0 = 3'd4;
    s0 = 1'b1;
    t = cyc + 1;
    q0.push_back('{4'b0110, 3'd4, 1'b1, 1'b0, t + 5});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s0 = 1'b0;
      chk("u0 probe_point", int'({a0, b0}), i);
    end
    wait_idle(1'b0);
    for (int s = 0; s < 8; s++) begin
      go2(3'(s), 2'b00, 1'b1, ett[s], 3'(esf[s]), 1'b1, 1'b0, t);
      @(negedge clk);
      s2 = 1'b0;
      wait_idle(1'b1);
    end
    go2(3'd0, 2'b11, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b1, t);
    @(negedge clk);
    s2 = 1'b0;
    wait_idle(1'b1);
    go2(3'd0, 2'b10, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, t);
    @(negedge clk);
    s2 = 1'b0;
    wait_idle(1'b1);
    go2(3'd5, 2'b00, 1'b1, 4'b1001, 3'd5, 1'b1, 1'b0, t);
    @(negedge clk);
    s2 = 1'b0;
    wait_idle(1'b1);
    go2(3'd3, 2'b00, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, t);
    @(negedge clk);
    s2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", int'(busy2), 0);
    chk("abort done", int'(done2), 0);
    chk("abort truth", int'(tr2), 0);
    chk("abort sel_found", int'(sf2), 0);
    chk("abort valid_err", int'({v2, e2}), 0);
    chk("abort probes", int'({a2, b2}), 0);
    repeat (20) @(negedge clk);
    go2(3'd1, 2'b00, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0, t);
    @(negedge clk);
    s2 = 1'b0;
    wait_idle(1'b1);
    go2(3'd2, 2'b00, 1'b1, 4'b1000, 3'd2, 1'b1, 1'b0, t);
    @(negedge clk);
    s2 = 1'b0;
    @(negedge clk);
    s2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    s2 = 1'b1;
    q2.push_back('{4'b1000, 3'd2, 1'b1, 1'b0, t + 14 + 13});
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b first_done_seen", int'(done2), 1);
    @(negedge clk);
    chk("b2b busy_after_done", int'(busy2), 1);
    chk("b2b done_low", int'(done2), 0);
    s2 = 1'b0;
    wait_idle(1'b1);
    repeat (3) @(negedge clk);
    chk("pending expectations", q0.size() + q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
